// File: rtl/kron_d2_scheduler.sv
// kron_d2_scheduler: arbitrates two requesters onto one fixed-latency masked zero-test unit.
// Build option KRON_PRIO_EN: fixed priority (req0 wins) instead of round-robin arbitration.
module kron_d2_scheduler #(
    parameter int KRON_LAT = 3,
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [23:0]      req0_data,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [23:0]      req1_data,
    input  logic [TAG_W-1:0] req1_tag,
    input  logic [12:0]      rnd_in,
    input  logic             rnd_valid,
    input  logic             halt,
    output logic             idle,
    output logic             rnd_err,
    output logic [23:0]      kron_inp,
    output logic [12:0]      kron_rnd,
    input  logic [2:0]       kron_out,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [TAG_W-1:0] resp_tag,
    output logic [2:0]       resp_out
);
    localparam int CW = $clog2(KRON_LAT + 2);

    typedef enum logic [1:0] {FLUSH, RUN, DRAIN, HALTED} state_t;

    state_t                       state_q;
    logic [CW-1:0]                flush_q;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic                         gnt, sel;
    logic [KRON_LAT:0]            v_q, id_q;
    logic [KRON_LAT:0][TAG_W-1:0] tag_q;
`ifndef KRON_PRIO_EN
    logic                         last_q;
`endif

    // Grant decision and requester select (sel=1 picks req1); rst_n keeps readies low during reset
    always_comb begin
        gnt = rst_n && state_q == RUN && !halt && rnd_valid && (req0_valid || req1_valid);
`ifdef KRON_PRIO_EN
        sel = !req0_valid;
`else
        sel = (req0_valid && req1_valid) ? !last_q : req1_valid;
`endif
        req0_ready = gnt && !sel;
        req1_ready = gnt && sel;
        cnt_d = cnt_q + CW'(gnt) - CW'(v_q[KRON_LAT]);
    end

    // Control FSM: flush the unreset unit pipeline, run, drain on halt, park until halt drops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FLUSH;
            flush_q <= '0;
            idle    <= 1'b0;
        end else begin
            case (state_q)
                FLUSH: begin
                    flush_q <= flush_q + 1'b1;
                    if (flush_q == CW'(KRON_LAT - 1)) state_q <= halt ? DRAIN : RUN;
                end
                RUN: if (halt) state_q <= DRAIN;
                DRAIN: if (cnt_q == '0) begin
                    state_q <= HALTED;
                    idle    <= 1'b1;
                end
                HALTED: if (!halt) begin
                    state_q <= RUN;
                    idle    <= 1'b0;
                end
            endcase
        end
    end

`ifndef KRON_PRIO_EN
    // Round-robin pointer remembers the last granted requester; reset makes req0 win first
    always_ff @(posedge clk) begin
        if (!rst_n) last_q <= 1'b1;
        else if (gnt) last_q <= sel;
    end
`endif

    // Datapath: unit operand/randomness, tag pipeline aligned with unit latency, in-flight count, response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kron_inp   <= '0;
            kron_rnd   <= '0;
            v_q        <= '0;
            id_q       <= '0;
            tag_q      <= '0;
            cnt_q      <= '0;
            rnd_err    <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_tag   <= '0;
            resp_out   <= '0;
        end else begin
            if (gnt) kron_inp <= sel ? req1_data : req0_data;
            if (rnd_valid) kron_rnd <= rnd_in;
            v_q   <= {v_q[KRON_LAT-1:0], gnt};
            id_q  <= {id_q[KRON_LAT-1:0], sel};
            tag_q <= {tag_q[KRON_LAT-1:0], sel ? req1_tag : req0_tag};
            cnt_q <= cnt_d;
            if (!rnd_valid && cnt_q != '0) rnd_err <= 1'b1;
            resp_valid <= v_q[KRON_LAT];
            if (v_q[KRON_LAT]) begin
                resp_id  <= id_q[KRON_LAT];
                resp_tag <= tag_q[KRON_LAT];
                resp_out <= kron_out;
            end
        end
    end
endmodule

// File: tb/tb_kron_d2_scheduler.sv
// tb_kron_d2_scheduler: directed checks of flush, latency, arbitration, halt/drain and randomness flag.
module tb_kron_d2_scheduler;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [23:0]      req0_data = '0, req1_data = '0;
    logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
    logic [12:0]      rnd_in = '0;
    logic             rnd_valid = 1'b1;
    logic             halt = 1'b0;
    logic             idle, rnd_err;
    logic [23:0]      kron_inp;
    logic [12:0]      kron_rnd;
    logic [2:0]       kron_out;
    logic             resp_valid, resp_id;
    logic [TAG_W-1:0] resp_tag;
    logic [2:0]       resp_out;

    int n_vec = 0;
    int n_err = 0;

`ifdef KRON_PRIO_EN
    localparam logic [3:0] EXP [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11};
`else
    localparam logic [3:0] EXP [8] = '{4'd0, 4'd8, 4'd1, 4'd9, 4'd2, 4'd10, 4'd3, 4'd11};
`endif

    kron_d2_scheduler #(.KRON_LAT(3), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_tag(req1_tag),
        .rnd_in(rnd_in), .rnd_valid(rnd_valid), .halt(halt), .idle(idle), .rnd_err(rnd_err),
        .kron_inp(kron_inp), .kron_rnd(kron_rnd), .kron_out(kron_out),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_tag(resp_tag), .resp_out(resp_out)
    );

    always #5 clk = ~clk;

    // Model of the 3-cycle masked zero-test unit: output shares XOR to 1 iff the shared byte is zero
    logic [2:0] st0 = '0, st1 = '0, st2 = '0;
    always @(posedge clk) begin
        st0 <= {kron_rnd[1], kron_rnd[0],
                ((kron_inp[23:16] ^ kron_inp[15:8] ^ kron_inp[7:0]) == 8'h00) ^ kron_rnd[0] ^ kron_rnd[1]};
        st1 <= st0;
        st2 <= st1;
    end
    assign kron_out = st2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        rnd_in = 13'($urandom);
    endtask

    int n0, n1;
    logic [3:0] gt;

    initial begin
        // Reset with both requesters valid, then flush and first accepts
        req0_valid = 1'b1; req0_data = 24'h665C3A; req0_tag = 4'd5;
        req1_valid = 1'b1; req1_data = 24'h25A347; req1_tag = 4'd2;
        tick;
        @(negedge clk);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        tick;
        rst_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("rst_resp_valid", resp_valid, 0);
                chk("rst_resp_tag", resp_tag, 0);
                chk("rst_kron_rnd", kron_rnd, 0);
                chk("rst_rnd_err", rnd_err, 0);
            end
            chk("flush_ready0", req0_ready, 0);
            chk("flush_ready1", req1_ready, 0);
            chk("flush_kron_inp", kron_inp, 0);
            chk("flush_idle", idle, 0);
            tick;
        end
        @(negedge clk);
        chk("c4_ready0", req0_ready, 1);
        chk("c4_ready1", req1_ready, 0);
        tick;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("c5_ready1", req1_ready, 1);
        chk("c5_kron_inp", kron_inp, 24'h665C3A);
        tick;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("c6_kron_inp", kron_inp, 24'h25A347);
        for (int c = 6; c <= 11; c++) begin
            if (c > 6) @(negedge clk);
            chk("lat_resp_valid", resp_valid, (c == 9 || c == 10));
            if (c == 9) begin
                chk("zero_id", resp_id, 0);
                chk("zero_tag", resp_tag, 5);
                chk("zero_xor", ^resp_out, 1);
            end
            if (c == 10) begin
                chk("nz_id", resp_id, 1);
                chk("nz_tag", resp_tag, 2);
                chk("nz_xor", ^resp_out, 0);
            end
            chk("run_idle", idle, 0);
            tick;
        end

        // Contention after a fresh reset
        rst_n = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        tick; tick; tick;
        n0 = 0; n1 = 0;
        for (int k = 0; k < 13; k++) begin
            req0_valid = (n0 < 4); req0_tag = 4'(n0);     req0_data = 24'h665C3A;
            req1_valid = (n1 < 4); req1_tag = 4'(8 + n1); req1_data = 24'h25A347;
            @(negedge clk);
            if (k < 8) begin
                gt = req0_ready ? req0_tag : (req1_ready ? req1_tag : 4'hF);
                chk("cont_gnt", gt, EXP[k]);
                n0 += int'(req0_ready);
                n1 += int'(req1_ready);
            end
            if (k >= 5) begin
                chk("cont_resp_valid", resp_valid, 1);
                chk("cont_resp_tag", resp_tag, EXP[k-5]);
                chk("cont_resp_id", resp_id, EXP[k-5] >= 8);
                chk("cont_resp_xor", ^resp_out, EXP[k-5] < 8);
            end
            tick;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("cont_tail", resp_valid, 0);
        tick;

        // Halt with two operations in flight
        req0_valid = 1'b1; req0_tag = 4'd6; req1_valid = 1'b1; req1_tag = 4'd7;
        @(negedge clk);
        chk("h_gnt0", req0_ready, 1);
        tick;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("h_gnt1", req1_ready, 1);
        tick;
        halt = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        for (int j = 2; j <= 8; j++) begin
            if (j == 8) halt = 1'b0;
            @(negedge clk);
            chk("h_ready0", req0_ready, 0);
            chk("h_ready1", req1_ready, 0);
            chk("h_resp_valid", resp_valid, (j == 5 || j == 6));
            if (j == 5) chk("h_tag6", resp_tag, 6);
            if (j == 6) chk("h_tag7", resp_tag, 7);
            chk("h_idle", idle, (j >= 7));
            tick;
        end
        req1_valid = 1'b0; req0_tag = 4'd3;
        @(negedge clk);
        chk("resume_ready0", req0_ready, 1);
        chk("resume_idle", idle, 0);
        tick;

        // Randomness starvation with one operation in flight
        rnd_valid = 1'b0;
        @(negedge clk);
        chk("starve_no_gnt", req0_ready, 0);
        chk("starve_err_pre", rnd_err, 0);
        tick;
        rnd_valid = 1'b1; req0_valid = 1'b0;
        for (int j = 11; j <= 15; j++) begin
            @(negedge clk);
            chk("starve_err", rnd_err, 1);
            chk("starve_resp_valid", resp_valid, (j == 14));
            if (j == 14) chk("starve_tag", resp_tag, 3);
            tick;
        end

        // Reset with an operation in flight; starvation with nothing in flight is harmless
        req0_valid = 1'b1; req0_tag = 4'd9;
        @(negedge clk);
        chk("pre_rst_gnt", req0_ready, 1);
        tick;
        req0_valid = 1'b0;
        tick;
        rst_n = 1'b0; rnd_valid = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            if (c == 4) rnd_valid = 1'b1;
            @(negedge clk);
            chk("post_rst_err", rnd_err, 0);
            chk("post_rst_resp", resp_valid, 0);
            tick;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
